gpr_sb: RTL and testbench
=========================

Name: gpr_sb

Overview:
- Parametrised successor to the two-read/one-write general purpose register file.
- Provides RD_PORTS combinational read ports with same-cycle write-to-read bypass, and WR_PORTS writeback ports.
- Adds a per-register pending-write scoreboard; the decode stage uses it to detect RAW hazards and generate a stall.
- Sits between the decoder (read addresses, destination issue) and the writeback stage (results).

Parameters:
- DATA_WIDTH, 32, register width.
- ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH.
- RD_PORTS, 2, number of read ports.
- WR_PORTS, 2, number of writeback ports.
- CNT_WIDTH, 2, width of each per-register pending counter.
- ZERO_REG, 1, when 1, register 0 reads as zero and ignores writes and issues.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  RD_PORTS*ADDR_WIDTH  read addresses; port p occupies bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- rd_use  in  RD_PORTS  port p operand is actually consumed by the current instruction.
- rd_data  out  RD_PORTS*DATA_WIDTH  read data (combinational).
- rd_busy  out  RD_PORTS  read register still has an outstanding write not satisfied this cycle.
- stall  out  1  OR over p of (rd_use[p] & rd_busy[p]).
- iss_en  in  1  reserve destination register iss_addr.
- iss_addr  in  ADDR_WIDTH  destination register being issued.
- iss_ok  out  1  pending counter of iss_addr is below its maximum, so an issue is accepted.
- wr_en  in  WR_PORTS  writeback valid, one bit per port.
- wr_addr  in  WR_PORTS*ADDR_WIDTH  writeback addresses.
- wr_data  in  WR_PORTS*DATA_WIDTH  writeback data.
- flush  in  1  clear all pending counters.
- sb_err  out  1  sticky flag: writeback to a register with count 0, or issue rejected.

Behaviour:
- Reset (synchronous): all registers, all counters and sb_err = 0.
  - Combinational outputs then evaluate to rd_data = 0, rd_busy = 0, stall = 0, iss_ok = 1.
- Register write:
  - On the clock edge, for every wr_en[k] with a non-zero address (or any address when ZERO_REG = 0), reg[wr_addr[k]] <= wr_data[k].
  - Multiple ports hitting the same address: the highest index k wins.
- Read, combinational, zero latency:
  - If ZERO_REG and rd_addr = 0: rd_data = 0, rd_busy = 0.
  - Else, if any wr_en[k] matches rd_addr: bypass wr_data of the highest matching k.
  - Else: reg[rd_addr].
- Write latency: data is visible on the bypass in the same cycle, and from the array in the next cycle.
- Pending counter cnt[r], CNT_WIDTH bits per register:
  - inc = iss_en & iss_ok & (iss_addr == r) & ~flush & ~(ZERO_REG & r == 0).
  - dec = number of wr_en[k] with wr_addr[k] == r.
  - cnt_next = flush ? 0 : clamp(cnt + inc - dec, 0, 2**CNT_WIDTH - 1).
  - Underflow clamps to 0.
- rd_busy[p] = (cnt[rd_addr[p]] > number of writebacks matching rd_addr[p] this cycle). A write completing in this cycle therefore does not stall its consumer.
- iss_ok = (cnt[iss_addr] != all ones) | (iss_addr matched by some wr_en this cycle).
  - An issue with iss_ok = 0 is dropped and sets sb_err.
- sb_err is set next cycle when any writeback hits a register whose cnt is 0 (excluding register 0 when ZERO_REG).
  - It is cleared only by reset.
- Issue and writeback to the same register in the same cycle net to zero change.
- flush:
  - Writebacks in the flush cycle still update the array.
  - Issues in the flush cycle are ignored.
  - Counters read 0 on the next cycle.
- Reset mid-operation overrides flush, issue and write in that cycle.

Test Plan:
- Reset, then write reg[i] = i for i = 1..31 via port 0 → rd_addr = {5, 3} returns {5, 3}. rd_addr = 0 returns 0 after an attempted write of 0xFFFF_FFFF to register 0.
- Bypass: wr_en[0], wr_addr = 7, wr_data = 0xDEAD_BEEF; same cycle rd_addr[1] = 7 → rd_data[1] = 0xDEAD_BEEF, and the array holds it next cycle. Ports 0 and 1 both write reg 9 (0x11, 0x22) → 0x22 stored.
- Hazard: issue reg 4, next cycle rd_addr[0] = 4 with rd_use = 01 → rd_busy[0] = 1, stall = 1. With rd_use = 00 → stall = 0. Writeback reg 4 in a cycle → rd_busy[0] = 0 that cycle, count 0 afterwards.
- Saturation: issue reg 6 three times (count 3), a fourth issue → iss_ok = 0, count stays 3, sb_err = 1. A fourth issue together with a writeback to reg 6 → accepted, count stays 3.
- Flush: counts reg 2 = 2, reg 3 = 1. Assert flush with issue reg 5 and write reg 2 = 0xAA → next cycle all rd_busy = 0, reg 5 not busy, reg 2 = 0xAA.
- Underflow: writeback reg 10 with count 0 → data written, count 0, sb_err = 1 next cycle. Reset → sb_err = 0 and reg 10 = 0.

Source files
------------

// File: rtl/gpr_sb.sv
// Multi-port general purpose register file with same-cycle write bypass and a
// per-register pending-write scoreboard used by decode for RAW stall detection.
module gpr_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_PORTS   = 2,
  parameter int WR_PORTS   = 2,
  parameter int CNT_WIDTH  = 2,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
  input  logic [RD_PORTS-1:0]            rd_use,
  output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [RD_PORTS-1:0]            rd_busy,
  output logic                           stall,
  input  logic                           iss_en,
  input  logic [ADDR_WIDTH-1:0]          iss_addr,
  output logic                           iss_ok,
  input  logic [WR_PORTS-1:0]            wr_en,
  input  logic [WR_PORTS*ADDR_WIDTH-1:0] wr_addr,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                           flush,
  output logic                           sb_err
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam int MW       = $clog2(WR_PORTS + 1);
  localparam int SW       = ((CNT_WIDTH > MW) ? CNT_WIDTH : MW) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [CNT_WIDTH-1:0]  r_cnt  [NUM_REGS];
  logic                  r_sb_err;

  logic [MW-1:0]         w_hits    [NUM_REGS];
  logic [CNT_WIDTH-1:0]  w_cnt_nxt [NUM_REGS];
  logic                  w_err_set;

  function automatic logic [MW-1:0] f_hits(
    input logic [ADDR_WIDTH-1:0]          a,
    input logic [WR_PORTS-1:0]            en,
    input logic [WR_PORTS*ADDR_WIDTH-1:0] wa
  );
    logic [MW-1:0] n;
    n = '0;
    for (int k = 0; k < WR_PORTS; k++)
      if (en[k] && wa[k*ADDR_WIDTH +: ADDR_WIDTH] == a) n = n + MW'(1);
    return n;
  endfunction

  // Saturating cnt + inc - dec, clamped to [0, CNT_MAX].
  function automatic logic [CNT_WIDTH-1:0] f_cnt_next(
    input logic [CNT_WIDTH-1:0] c,
    input logic                 inc,
    input logic [MW-1:0]        dec
  );
    logic [SW-1:0] s;
    s = SW'(c) + SW'(inc);
    if (s <= SW'(dec)) return '0;
    s = s - SW'(dec);
    if (s > SW'(CNT_MAX)) return CNT_MAX;
    return CNT_WIDTH'(s);
  endfunction

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      w_hits[r] = f_hits(ADDR_WIDTH'(r), wr_en, wr_addr);
  end

  // Issue handshake: iss_en is the request, iss_ok the acceptance; an issue
  // takes effect only in a cycle where both are high, otherwise it is dropped.
  assign iss_ok = (r_cnt[iss_addr] != CNT_MAX) || (w_hits[iss_addr] != '0);

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      w_cnt_nxt[r] = f_cnt_next(r_cnt[r],
                                iss_en && iss_ok && (iss_addr == ADDR_WIDTH'(r)) &&
                                !flush && !(ZERO_REG && r == 0),
                                w_hits[r]);
  end

  always_comb begin
    w_err_set = iss_en && !iss_ok && !flush;
    for (int k = 0; k < WR_PORTS; k++)
      if (wr_en[k] && r_cnt[wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] == '0 &&
          !(ZERO_REG && wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == '0))
        w_err_set = 1'b1;
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic [DATA_WIDTH-1:0] w_rd;
    logic                  w_zero;

    assign w_ra   = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_zero = ZERO_REG && (w_ra == '0);

    // Later write ports override earlier ones, matching the array priority.
    always_comb begin
      w_rd = r_regs[w_ra];
      for (int k = 0; k < WR_PORTS; k++)
        if (wr_en[k] && wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == w_ra)
          w_rd = wr_data[k*DATA_WIDTH +: DATA_WIDTH];
      if (w_zero) w_rd = '0;
    end

    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = w_rd;
    assign rd_busy[p] = !w_zero && (SW'(r_cnt[w_ra]) > SW'(w_hits[w_ra]));
  end

  assign stall  = |(rd_use & rd_busy);
  assign sb_err = r_sb_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
        r_cnt[r]  <= '0;
      end
      r_sb_err <= 1'b0;
    end else begin
      for (int k = 0; k < WR_PORTS; k++)
        if (wr_en[k] && !(ZERO_REG && wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == '0))
          r_regs[wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[k*DATA_WIDTH +: DATA_WIDTH];
      for (int r = 0; r < NUM_REGS; r++)
        r_cnt[r] <= flush ? '0 : w_cnt_nxt[r];
      if (w_err_set) r_sb_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gpr_sb.sv
// Directed bench for gpr_sb: register read/write, bypass, hazard scoreboard,
// saturation, flush, underflow and reset behaviour with hand-computed values.
module tb_gpr_sb;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_use;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        stall;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        iss_ok;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        flush;
  logic        sb_err;

  int n_checks = 0;
  int n_errors = 0;

  gpr_sb dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_use(rd_use),
    .rd_data(rd_data), .rd_busy(rd_busy), .stall(stall), .iss_en(iss_en),
    .iss_addr(iss_addr), .iss_ok(iss_ok), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .flush(flush), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_en = 1'b0; iss_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    flush = 1'b0; rd_use = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rd_addr = '0;
    idle();
    step(); step();
    reset = 1'b0;
    rd_addr = {5'd5, 5'd3}; rd_use = 2'b11; iss_addr = 5'd6;
    #1;
    n_checks++; if (rd_data !== 64'd0) begin n_errors++; $display("FAIL reset_rd_data: got %h want %h", rd_data, 64'd0); end
    n_checks++; if (rd_busy !== 2'b00) begin n_errors++; $display("FAIL reset_rd_busy: got %b want 00", rd_busy); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_checks++; if (iss_ok !== 1'b1) begin n_errors++; $display("FAIL reset_iss_ok: got %b want 1", iss_ok); end
    n_checks++; if (sb_err !== 1'b0) begin n_errors++; $display("FAIL reset_sb_err: got %b want 0", sb_err); end
  endtask

  task automatic test_write_read();
    idle();
    for (int i = 1; i < 32; i++) begin
      wr_en = 2'b01; wr_addr = {5'd0, 5'(i)}; wr_data = {32'd0, 32'(i)};
      step();
    end
    wr_en = 2'b01; wr_addr = 10'd0; wr_data = {32'd0, 32'hFFFF_FFFF};
    rd_addr = 10'd0;
    #1;
    n_checks++; if (rd_data[31:0] !== 32'd0) begin n_errors++; $display("FAIL zero_bypass: got %h want 0", rd_data[31:0]); end
    step();
    idle();
    rd_addr = {5'd5, 5'd3};
    #1;
    n_checks++; if (rd_data[31:0] !== 32'd3) begin n_errors++; $display("FAIL read_p0_3: got %h want 3", rd_data[31:0]); end
    n_checks++; if (rd_data[63:32] !== 32'd5) begin n_errors++; $display("FAIL read_p1_5: got %h want 5", rd_data[63:32]); end
    rd_addr = 10'd0;
    #1;
    n_checks++; if (rd_data[31:0] !== 32'd0) begin n_errors++; $display("FAIL zero_reg: got %h want 0", rd_data[31:0]); end
    for (int i = 1; i < 32; i++) begin
      rd_addr = {5'(32 - i), 5'(i)};
      #1;
      n_checks++; if (rd_data[31:0] !== 32'(i)) begin n_errors++; $display("FAIL reg_p0_%0d: got %h want %h", i, rd_data[31:0], 32'(i)); end
      n_checks++; if (rd_data[63:32] !== 32'(32 - i)) begin n_errors++; $display("FAIL reg_p1_%0d: got %h want %h", 32 - i, rd_data[63:32], 32'(32 - i)); end
    end
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'd0, 32'hDEAD_BEEF};
    rd_addr = {5'd7, 5'd0};
    #1;
    n_checks++; if (rd_data[63:32] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL bypass_same_cycle: got %h want deadbeef", rd_data[63:32]); end
    step();
    idle();
    #1;
    n_checks++; if (rd_data[63:32] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL bypass_array: got %h want deadbeef", rd_data[63:32]); end
    wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'h22, 32'h11};
    rd_addr = {5'd7, 5'd9};
    #1;
    n_checks++; if (rd_data[31:0] !== 32'h22) begin n_errors++; $display("FAIL bypass_priority: got %h want 22", rd_data[31:0]); end
    step();
    idle();
    rd_addr = {5'd9, 5'd9};
    #1;
    n_checks++; if (rd_data[31:0] !== 32'h22) begin n_errors++; $display("FAIL dual_write_p0: got %h want 22", rd_data[31:0]); end
    n_checks++; if (rd_data[63:32] !== 32'h22) begin n_errors++; $display("FAIL dual_write_p1: got %h want 22", rd_data[63:32]); end
  endtask

  task automatic test_hazard();
    idle();
    iss_en = 1'b1; iss_addr = 5'd4;
    #1;
    n_checks++; if (iss_ok !== 1'b1) begin n_errors++; $display("FAIL haz_iss_ok: got %b want 1", iss_ok); end
    step();
    idle();
    rd_addr = {5'd4, 5'd4}; rd_use = 2'b01;
    #1;
    n_checks++; if (rd_busy !== 2'b11) begin n_errors++; $display("FAIL haz_busy: got %b want 11", rd_busy); end
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL haz_stall: got %b want 1", stall); end
    rd_use = 2'b00;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL haz_nouse: got %b want 0", stall); end
    rd_addr = {5'd0, 5'd4}; rd_use = 2'b10;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL haz_p1_zero: got %b want 0", stall); end
    rd_use = 2'b01; wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'd0, 32'h44};
    #1;
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_errors++; $display("FAIL haz_wb_busy: got %b want 0", rd_busy[0]); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL haz_wb_stall: got %b want 0", stall); end
    n_checks++; if (rd_data[31:0] !== 32'h44) begin n_errors++; $display("FAIL haz_wb_data: got %h want 44", rd_data[31:0]); end
    step();
    idle();
    rd_addr = {5'd0, 5'd4};
    #1;
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_errors++; $display("FAIL haz_after_busy: got %b want 0", rd_busy[0]); end
    n_checks++; if (rd_data[31:0] !== 32'h44) begin n_errors++; $display("FAIL haz_after_data: got %h want 44", rd_data[31:0]); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      iss_en = 1'b1; iss_addr = 5'd6;
      #1;
      n_checks++; if (iss_ok !== 1'b1) begin n_errors++; $display("FAIL sat_iss_ok_%0d: got %b want 1", i, iss_ok); end
      step();
    end
    idle();
    n_checks++; if (sb_err !== 1'b0) begin n_errors++; $display("FAIL sat_err_pre: got %b want 0", sb_err); end
    iss_en = 1'b1; iss_addr = 5'd6;
    #1;
    n_checks++; if (iss_ok !== 1'b0) begin n_errors++; $display("FAIL sat_full: got %b want 0", iss_ok); end
    step();
    idle();
    iss_addr = 5'd6; rd_addr = {5'd0, 5'd6};
    #1;
    n_checks++; if (sb_err !== 1'b1) begin n_errors++; $display("FAIL sat_err: got %b want 1", sb_err); end
    n_checks++; if (iss_ok !== 1'b0) begin n_errors++; $display("FAIL sat_still_full: got %b want 0", iss_ok); end
    iss_en = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd6}; wr_data = {32'd0, 32'h66};
    #1;
    n_checks++; if (iss_ok !== 1'b1) begin n_errors++; $display("FAIL sat_wb_accept: got %b want 1", iss_ok); end
    step();
    idle();
    iss_addr = 5'd6;
    #1;
    n_checks++; if (iss_ok !== 1'b0) begin n_errors++; $display("FAIL sat_net_zero: got %b want 0", iss_ok); end
    n_checks++; if (rd_busy[0] !== 1'b1) begin n_errors++; $display("FAIL sat_busy: got %b want 1", rd_busy[0]); end
  endtask

  task automatic test_flush();
    do_reset();
    iss_en = 1'b1; iss_addr = 5'd2; step();
    step();
    iss_addr = 5'd3; step();
    idle();
    rd_addr = {5'd3, 5'd2};
    #1;
    n_checks++; if (rd_busy !== 2'b11) begin n_errors++; $display("FAIL flush_pre_busy: got %b want 11", rd_busy); end
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd5;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd2}; wr_data = {32'd0, 32'hAA};
    step();
    idle();
    #1;
    n_checks++; if (rd_busy !== 2'b00) begin n_errors++; $display("FAIL flush_busy: got %b want 00", rd_busy); end
    n_checks++; if (rd_data[31:0] !== 32'hAA) begin n_errors++; $display("FAIL flush_wb_data: got %h want aa", rd_data[31:0]); end
    rd_addr = {5'd0, 5'd5};
    #1;
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_errors++; $display("FAIL flush_iss_ignored: got %b want 0", rd_busy[0]); end
    n_checks++; if (sb_err !== 1'b0) begin n_errors++; $display("FAIL flush_sb_err: got %b want 0", sb_err); end
  endtask

  task automatic test_underflow();
    do_reset();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'd0, 32'h1234};
    rd_addr = {5'd0, 5'd10};
    #1;
    n_checks++; if (sb_err !== 1'b0) begin n_errors++; $display("FAIL uf_err_pre: got %b want 0", sb_err); end
    step();
    idle();
    #1;
    n_checks++; if (sb_err !== 1'b1) begin n_errors++; $display("FAIL uf_err: got %b want 1", sb_err); end
    n_checks++; if (rd_data[31:0] !== 32'h1234) begin n_errors++; $display("FAIL uf_data: got %h want 1234", rd_data[31:0]); end
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_errors++; $display("FAIL uf_busy: got %b want 0", rd_busy[0]); end
    reset = 1'b1; iss_en = 1'b1; iss_addr = 5'd10;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'd0, 32'h55};
    step();
    reset = 1'b0;
    idle();
    #1;
    n_checks++; if (sb_err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b want 0", sb_err); end
    n_checks++; if (rd_data[31:0] !== 32'd0) begin n_errors++; $display("FAIL rst_data: got %h want 0", rd_data[31:0]); end
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b want 0", rd_busy[0]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_hazard();
    test_saturation();
    test_flush();
    test_underflow();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
